// File: rtl/md_unit.sv
// md_unit -- multi-cycle multiply/divide unit holding the architectural HI/LO
// registers of the pipelined MIPS core. It sits in the E stage beside the ALU.
// The stall controller uses busy to hold the pipeline while a result is pending.
//
// Ports
//   clk    in   1   core clock, rising edge
//   reset  in   1   asynchronous, active-low; clears all state
//   start  in   1   E-stage op valid (one-cycle pulse per instruction)
//   md_op  in   3   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU
//   A      in   32  rs operand (forwarded)
//   B      in   32  rt operand (forwarded)
//   busy   out  1   computation in progress
//   HI     out  32  HI register
//   LO     out  32  LO register
//
// Configuration
//   MD_MADD_EN  when defined, md_op 6/7 accumulate A*B into {HI,LO}.
//               When undefined, md_op 6/7 are accepted as no-ops.
//
// Any start that arrives while busy is dropped, including MTHI/MTLO. The
// result is evaluated from the latched operands on the final busy edge.
// This keeps the operand path stable regardless of forwarding activity.

module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_MADD  = 3'd6,
        OP_MADDU = 3'd7
    } md_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    // 32x32 -> 64 product. The uns argument selects unsigned operands.
    function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                          input logic uns);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] p;
        sa = uns ? {32'd0, a} : {{32{a[31]}}, a};
        sb = uns ? {32'd0, b} : {{32{b[31]}}, b};
        p  = sa * sb;
        return p;
    endfunction

    // Divide; returns {remainder, quotient}.
    // Divide-by-zero and the single signed overflow case are handled explicitly.
    // This keeps their results defined independent of the operator semantics.
    function automatic logic [63:0] div64(input logic [31:0] a, input logic [31:0] b,
                                          input logic uns);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] q;
        logic signed [31:0] r;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            return {a, 32'hFFFF_FFFF};
        end else if (uns) begin
            return {a % b, a / b};
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            return {32'd0, 32'h8000_0000};
        end else begin
            q = sa / sb;      // truncates toward zero
            r = sa % sb;      // takes the sign of the dividend
            return {r, q};
        end
    endfunction

    state_e      state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [2:0]  op_q,    op_d;
    logic [31:0] a_q,     a_d;
    logic [31:0] b_q,     b_d;
    logic [31:0] hi_q,    hi_d;
    logic [31:0] lo_q,    lo_d;
    logic [63:0] result;

    always_comb begin
        result = mul64(a_q, b_q, op_q[0]);
        if (op_q[2:1] == 2'b01) begin
            result = div64(a_q, b_q, op_q[0]);
        end
`ifdef MD_MADD_EN
        // The accumulate reads HI/LO as they stand at completion time.
        if (op_q[2]) begin
            result = {hi_q, lo_q} + mul64(a_q, b_q, op_q[0]);
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (md_op_e'(md_op))
                        OP_MULT, OP_MULTU: begin
                            op_d    = md_op;
                            a_d     = A;
                            b_d     = B;
                            cnt_d   = MULT_CNT;
                            state_d = S_BUSY;
                        end
                        OP_DIV, OP_DIVU: begin
                            op_d    = md_op;
                            a_d     = A;
                            b_d     = B;
                            cnt_d   = DIV_CNT;
                            state_d = S_BUSY;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
`ifdef MD_MADD_EN
                        OP_MADD, OP_MADDU: begin
                            op_d    = md_op;
                            a_d     = A;
                            b_d     = B;
                            cnt_d   = MULT_CNT;
                            state_d = S_BUSY;
                        end
`else
                        OP_MADD, OP_MADDU: ;
`endif
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                // The last busy cycle ends at the same edge that writes the result.
                if (cnt_q == 4'd1) begin
                    hi_d    = result[63:32];
                    lo_d    = result[31:0];
                    cnt_d   = 4'd0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 3'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == S_BUSY);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
